uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the lab designs: it deserialises an 8N1 UART stream on a single input line into parallel bytes. It is the receiving end of the team's UART link and pairs with the serial transmitter on the same line format: idle-high, one start bit, LSB-first data, one stop bit. It synchronises the line, validates the start bit at mid-bit, samples each data bit at its centre, checks the stop bit, and reports either a one-cycle VALID pulse or a one-cycle FRAME_ERR pulse.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- DATA_BITS, default 8: data bits per frame. Range 5–8.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- RX  input  1  serial line; idle high; asynchronous to clk.
- DATA  output  DATA_BITS  last correctly received byte, LSB = first data bit.
- VALID  output  1  one-cycle pulse; DATA was updated on the same edge.
- FRAME_ERR  output  1  one-cycle pulse when a sampled stop bit is low.
- BUSY  output  1  high in any state other than IDLE.

## Operation
- RX passes through a 2-flop synchroniser. The second flop, rx_s, is reset to 1. Only rx_s is used internally.
- Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT. There is one bit counter cnt (enough bits to reach N-1) and one bit index idx.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - If rx_s == 0, go to START with cnt = 0.
- START:
  - cnt increments each cycle.
  - When cnt == H-1, sample rx_s.
  - If rx_s == 0, go to DATA with cnt = 0 and idx = 0.
  - If rx_s == 1, this is a glitch or false start: go to IDLE and produce no output pulse.
- DATA:
  - When cnt == N-1, shift rx_s into the shift register from the MSB side (LSB-first reception), then set cnt = 0 and idx = idx+1.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - When cnt == N-1, sample rx_s.
  - If rx_s == 1: load DATA from the shift register, pulse VALID, and go to IDLE.
  - If rx_s == 0: pulse FRAME_ERR, leave DATA unchanged, and go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay here until rx_s == 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- VALID and FRAME_ERR are never high in the same cycle. Each is high for exactly one cycle per frame.
- Back-to-back frames: the receiver returns to IDLE at the mid-stop-bit point. A start bit arriving immediately after the stop bit is therefore detected without loss.
- Reset values: DATA = 0, VALID = 0, FRAME_ERR = 0, BUSY = 0, state = IDLE, synchroniser flops = 1, cnt = 0, idx = 0.
- An rst assertion mid-frame aborts the frame immediately. No VALID pulse follows, and the next falling edge after release starts a fresh frame.

## Timing
- Let E0 be the first rising edge at which the first synchroniser flop captures RX = 0 (the start-bit edge).
  - rx_s is low after E1.
  - The state machine enters START at E2.
  - Leaving START for DATA happens at E2+H.
  - Data bit k (k = 1..DATA_BITS) is sampled at E2+H+k·N.
  - The stop bit is sampled at E2+H+(DATA_BITS+1)·N. VALID or FRAME_ERR is high in the clock cycle following that edge.
- With the default parameters, VALID is registered at E154 and the frame period is 160 cycles.
- Sampling tolerance: the sample point is at mid-bit. Cumulative baud mismatch of up to ±H-1 cycles over the frame is absorbed.
- BUSY rises at E2 and falls on the same edge that registers VALID (or when WAIT_IDLE exits).

## Test plan
- Single frame: default parameters, send 0xA5 at 16 cycles/bit. Required: VALID high for exactly 1 cycle at E154, DATA = 0xA5, FRAME_ERR = 0 throughout.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap. Required: three VALID pulses spaced 160 cycles apart, carrying DATA 0x00, 0xFF and 0x3C in order.
- False start: RX low for 3 cycles, then high. Required: BUSY high briefly, return to IDLE, and no VALID or FRAME_ERR pulse.
- Framing error / break: send 0x55 with the stop bit forced low, then hold RX low for 400 cycles. Required:
  - a single FRAME_ERR pulse;
  - DATA keeps its previous value;
  - no further pulses while RX stays low;
  - after RX returns high, a subsequent 0x81 frame gives VALID with DATA = 0x81.
- Reset mid-frame: assert rst during data bit 4 of 0xC3. Required: all outputs go to their reset values immediately with no later VALID; a fresh 0x7E frame after release is received correctly.
- Parameter sweep: CLKS_PER_BIT = 4 and DATA_BITS = 5, send 0x15. Required: VALID at E2+2+6·4 = E28 with DATA = 0x15.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver. The line is synchronised, the start bit
// is confirmed at mid-bit, each data bit is sampled at its centre (LSB first),
// and the stop bit decides between a VALID pulse and a FRAME_ERR pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q;
    logic                 rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= RX;
            rx_s_q  <= sync1_q;
        end
    end

    // Next-state and next-output logic; counters restart at every bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at mid-start-bit was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                // Hold off until the line recovers so a break is not read as 0x00 frames.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: default instance plus a CLKS_PER_BIT=4 / DATA_BITS=5 instance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, busy_a;
    logic [4:0] data_b;
    logic       valid_b, ferr_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         va_t[$];
    logic [7:0] va_d[$];
    int         fa_t[$];
    int         vb_t[$];
    logic [4:0] vb_d[$];
    int         fb_t[$];
    logic       busy_seen;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .RX(rx_a),
        .DATA(data_a), .VALID(valid_a), .FRAME_ERR(ferr_a), .BUSY(busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut_b (
        .clk(clk), .rst(rst), .RX(rx_b),
        .DATA(data_b), .VALID(valid_b), .FRAME_ERR(ferr_b), .BUSY(busy_b)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc = cyc + 1;

    // Pulse logger, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (valid_a) begin va_t.push_back(cyc); va_d.push_back(data_a); end
        if (ferr_a)  fa_t.push_back(cyc);
        if (valid_b) begin vb_t.push_back(cyc); vb_d.push_back(data_b); end
        if (ferr_b)  fb_t.push_back(cyc);
        if (busy_a)  busy_seen = 1'b1;
    end

    task automatic clear_logs();
        va_t.delete(); va_d.delete(); fa_t.delete();
        vb_t.delete(); vb_d.delete(); fb_t.delete();
        busy_seen = 1'b0;
    endtask

    // Drives the first nbits of a 16-cycle/bit frame on rx_a; e0 is the edge that
    // first captures the start bit. Must be entered and leaves #1 after an edge.
    task automatic send_frame_a(input logic [7:0] d, input logic stop_bit,
                                input int nbits, output int e0);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        e0 = cyc + 1;
        for (int i = 0; i < nbits; i++) begin
            rx_a = fr[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data_a !== 8'h00) begin n_err++; $display("FAIL reset_data act=%h req=00", data_a); end
        n_cmp++; if ({valid_a, ferr_a, busy_a} !== 3'b000) begin n_err++; $display("FAIL reset_flags act=%b req=000", {valid_a, ferr_a, busy_a}); end
        n_cmp++; if ({data_b, valid_b, ferr_b, busy_b} !== 8'h00) begin n_err++; $display("FAIL reset_b act=%h req=00", {data_b, valid_b, ferr_b, busy_b}); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("reset: outputs checked at reset state");
    endtask

    task automatic test_single();
        int e0;
        clear_logs();
        send_frame_a(8'hA5, 1'b1, 10, e0);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (va_t.size() != 1) begin
            n_err++; $display("FAIL single_count act=%0d req=1", va_t.size());
        end else begin
            n_cmp++; if (va_t[0] != e0 + 154) begin n_err++; $display("FAIL single_time act=%0d req=%0d", va_t[0] - e0, 154); end
            n_cmp++; if (va_d[0] !== 8'hA5) begin n_err++; $display("FAIL single_data act=%h req=a5", va_d[0]); end
        end
        n_cmp++; if (fa_t.size() != 0) begin n_err++; $display("FAIL single_ferr act=%0d req=0", fa_t.size()); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_busy_idle act=%b req=0", busy_a); end
        $display("single: sent a5, valid pulses=%0d", va_t.size());
    endtask

    task automatic test_back_to_back();
        int e0, e_tmp;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
        clear_logs();
        send_frame_a(exp_d[0], 1'b1, 10, e0);
        send_frame_a(exp_d[1], 1'b1, 10, e_tmp);
        send_frame_a(exp_d[2], 1'b1, 10, e_tmp);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (va_t.size() != 3) begin
            n_err++; $display("FAIL b2b_count act=%0d req=3", va_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (va_t[i] != e0 + 154 + 160 * i) begin n_err++; $display("FAIL b2b_time%0d act=%0d req=%0d", i, va_t[i] - e0, 154 + 160 * i); end
                n_cmp++; if (va_d[i] !== exp_d[i]) begin n_err++; $display("FAIL b2b_data%0d act=%h req=%h", i, va_d[i], exp_d[i]); end
            end
        end
        n_cmp++; if (fa_t.size() != 0) begin n_err++; $display("FAIL b2b_ferr act=%0d req=0", fa_t.size()); end
        $display("back_to_back: sent 00 ff 3c, valid pulses=%0d", va_t.size());
    endtask

    task automatic test_false_start();
        clear_logs();
        rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL false_busy_seen act=%b req=1", busy_seen); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL false_busy_end act=%b req=0", busy_a); end
        n_cmp++; if (va_t.size() + fa_t.size() != 0) begin n_err++; $display("FAIL false_pulses act=%0d req=0", va_t.size() + fa_t.size()); end
        n_cmp++; if (data_a !== 8'h3C) begin n_err++; $display("FAIL false_data act=%h req=3c", data_a); end
        $display("false_start: 3-cycle low glitch, pulses=%0d", va_t.size() + fa_t.size());
    endtask

    task automatic test_frame_error();
        int e0;
        clear_logs();
        send_frame_a(8'h55, 1'b0, 10, e0);
        repeat (400) @(posedge clk);
        #1;
        n_cmp++;
        if (fa_t.size() != 1) begin
            n_err++; $display("FAIL ferr_count act=%0d req=1", fa_t.size());
        end else begin
            n_cmp++; if (fa_t[0] != e0 + 154) begin n_err++; $display("FAIL ferr_time act=%0d req=154", fa_t[0] - e0); end
        end
        n_cmp++; if (va_t.size() != 0) begin n_err++; $display("FAIL ferr_valid act=%0d req=0", va_t.size()); end
        n_cmp++; if (data_a !== 8'h3C) begin n_err++; $display("FAIL ferr_data_kept act=%h req=3c", data_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL ferr_busy_break act=%b req=1", busy_a); end
        rx_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release act=%b req=0", busy_a); end
        clear_logs();
        send_frame_a(8'h81, 1'b1, 10, e0);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (va_t.size() != 1) begin
            n_err++; $display("FAIL ferr_recover_count act=%0d req=1", va_t.size());
        end else begin
            n_cmp++; if (va_d[0] !== 8'h81) begin n_err++; $display("FAIL ferr_recover_data act=%h req=81", va_d[0]); end
        end
        $display("frame_error: 55 with low stop + break, then 81 valid=%0d", va_t.size());
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        clear_logs();
        send_frame_a(8'hC3, 1'b1, 5, e0);
        rx_a = 1'b0;               // data bit 4 of 0xC3
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({data_a, valid_a, ferr_a, busy_a} !== 11'h000) begin n_err++; $display("FAIL rstmid_outputs act=%h req=000", {data_a, valid_a, ferr_a, busy_a}); end
        rx_a = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        n_cmp++; if (va_t.size() + fa_t.size() != 0) begin n_err++; $display("FAIL rstmid_no_pulse act=%0d req=0", va_t.size() + fa_t.size()); end
        send_frame_a(8'h7E, 1'b1, 10, e0);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (va_t.size() != 1) begin
            n_err++; $display("FAIL rstmid_fresh_count act=%0d req=1", va_t.size());
        end else begin
            n_cmp++; if (va_t[0] != e0 + 154) begin n_err++; $display("FAIL rstmid_fresh_time act=%0d req=154", va_t[0] - e0); end
            n_cmp++; if (va_d[0] !== 8'h7E) begin n_err++; $display("FAIL rstmid_fresh_data act=%h req=7e", va_d[0]); end
        end
        $display("reset_mid_frame: c3 aborted, 7e valid=%0d", va_t.size());
    endtask

    task automatic test_param_sweep();
        int e0;
        logic [6:0] fr;
        fr = {1'b1, 5'h15, 1'b0};
        clear_logs();
        e0 = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            rx_b = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (vb_t.size() != 1) begin
            n_err++; $display("FAIL sweep_count act=%0d req=1", vb_t.size());
        end else begin
            n_cmp++; if (vb_t[0] != e0 + 28) begin n_err++; $display("FAIL sweep_time act=%0d req=28", vb_t[0] - e0); end
            n_cmp++; if (vb_d[0] !== 5'h15) begin n_err++; $display("FAIL sweep_data act=%h req=15", vb_d[0]); end
        end
        n_cmp++; if (fb_t.size() != 0) begin n_err++; $display("FAIL sweep_ferr act=%0d req=0", fb_t.size()); end
        $display("param_sweep: 4 clk/bit 5 bits sent 15, valid=%0d", vb_t.size());
    endtask

    initial begin
        busy_seen = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
